// File: rtl/mod12_ctrl_pkg.sv
// Shared types and constants for the mod-12 counter controller.
package mod12_ctrl_pkg;

   localparam int unsigned CNT_W       = 4;
   localparam int unsigned MOD_MAX_DEF = 11;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StLoad,
      StClear
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request strictly after rr_ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   int unsigned k;

   always_comb begin
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      k         = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         k = (32'(rr_ptr) + i) % N_REQ;
         if (!gnt_valid && req[k[PTR_W-1:0]]) begin
            gnt_valid = 1'b1;
            gnt_idx   = k[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mod12_counter_ctrl.sv
// Sequences a shared loadable counter: run/hold, clear, forced 11->0 wrap and
// round-robin sharing of the counter load port between N_REQ requesters.
module mod12_counter_ctrl
   import mod12_ctrl_pkg::*;
#(
   parameter int unsigned N_REQ   = 2,
   parameter int unsigned MOD_MAX = MOD_MAX_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   clear,
   input  logic [N_REQ-1:0]       req,
   input  logic [CNT_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]       gnt,
   output logic                   req_err,
   input  logic [CNT_W-1:0]       cnt_q,
   output logic                   cnt_reset,
   output logic                   cnt_load,
   output logic [CNT_W-1:0]       cnt_data,
   output logic                   running,
   output logic                   wrap
);

   localparam int unsigned      PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MOD_MAX);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

   state_e             state_q, state_d;
   logic               run_mode_q, run_mode_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   ld_data_q, ld_data_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic               req_err_q, req_err_d;

   logic [PTR_W-1:0]   arb_idx;
   logic               arb_valid;
   logic [CNT_W-1:0]   sel_data;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req       (req),
      .rr_ptr    (rr_ptr_q),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (arb_idx == PTR_W'(i)) sel_data = req_data[CNT_W*i +: CNT_W];
      end
   end

   // stop dominates start; the new mode already steers this cycle's transition
   always_comb begin
      run_mode_d = run_mode_q;
      if (stop)       run_mode_d = 1'b0;
      else if (start) run_mode_d = 1'b1;
   end

   always_comb begin
      state_d   = run_mode_d ? StRun : StIdle;
      rr_ptr_d  = rr_ptr_q;
      ld_data_d = ld_data_q;
      gnt_d     = '0;
      req_err_d = 1'b0;
      unique case (state_q)
         StIdle, StRun: begin
            if (clear) begin
               state_d = StClear;
            end else if (arb_valid) begin
               gnt_d[arb_idx] = 1'b1;
               rr_ptr_d       = arb_idx;
               if (sel_data <= MAX_VAL) begin
                  ld_data_d = sel_data;
                  state_d   = StLoad;
               end else begin
                  req_err_d = 1'b1;
               end
            end
         end
         StLoad, StClear: ;
         default: state_d = StIdle;
      endcase
   end

   // The counter has no enable: holding means reloading its own Q.
   always_comb begin
      cnt_reset = ~reset;
      cnt_load  = 1'b0;
      cnt_data  = '0;
      wrap      = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_load = 1'b1;
            cnt_data = cnt_q;
         end
         StRun: begin
            if (cnt_q >= MAX_VAL) begin
               cnt_load = 1'b1;
               wrap     = 1'b1;
            end
         end
         StLoad: begin
            cnt_load = 1'b1;
            cnt_data = ld_data_q;
         end
         StClear: cnt_reset = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         run_mode_q <= 1'b0;
         rr_ptr_q   <= PTR_RST;
         ld_data_q  <= '0;
         gnt_q      <= '0;
         req_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         run_mode_q <= run_mode_d;
         rr_ptr_q   <= rr_ptr_d;
         ld_data_q  <= ld_data_d;
         gnt_q      <= gnt_d;
         req_err_q  <= req_err_d;
      end
   end

   assign gnt     = gnt_q;
   assign req_err = req_err_q;
   assign running = run_mode_q;

endmodule

// File: tb/tb_mod12_counter_ctrl.sv
// Directed bench: models the shared counter, scoreboards grant/error pulses, checks Q directly.
module tb_mod12_counter_ctrl;

   localparam int unsigned N = 2;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         err;
   } gexp_t;

   logic           clk;
   logic           reset;
   logic           start, stop, clear;
   logic [N-1:0]   req;
   logic [4*N-1:0] req_data;
   logic [N-1:0]   gnt;
   logic           req_err;
   logic [3:0]     cnt_q;
   logic           cnt_reset, cnt_load;
   logic [3:0]     cnt_data;
   logic           running, wrap;
   logic           glitch;

   int    vectors;
   int    miscompares;
   gexp_t gq[$];

   mod12_counter_ctrl #(
      .N_REQ   (N),
      .MOD_MAX (11)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .clear     (clear),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .req_err   (req_err),
      .cnt_q     (cnt_q),
      .cnt_reset (cnt_reset),
      .cnt_load  (cnt_load),
      .cnt_data  (cnt_data),
      .running   (running),
      .wrap      (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the shared synchronous loadable counter (glitch injects an illegal 12)
   initial cnt_q = 4'd0;
   always @(posedge clk) begin
      if (cnt_reset)     cnt_q <= 4'd0;
      else if (glitch)   cnt_q <= 4'd12;
      else if (cnt_load) cnt_q <= cnt_data;
      else               cnt_q <= cnt_q + 4'd1;
   end

   // Grant monitor: every gnt/req_err pulse must match the next queued expectation
   always @(negedge clk) begin
      if (reset && ((|gnt) || req_err)) begin
         vectors++;
         if (gq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_grant: got gnt=%b err=%b, required none", gnt, req_err);
         end else begin
            gexp_t e;
            e = gq.pop_front();
            if (gnt !== e.gnt || req_err !== e.err) begin
               miscompares++;
               $display("FAIL grant: got gnt=%b err=%b, required gnt=%b err=%b",
                        gnt, req_err, e.gnt, e.err);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [N-1:0] g, input logic err);
      gexp_t e;
      e.gnt = g;
      e.err = err;
      gq.push_back(e);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
      req = '0; req_data = '0; glitch = 1'b0;

      // Reset
      step(3);
      chk("rst_q", int'(cnt_q), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_err", int'(req_err), 0);
      chk("rst_cnt_reset", int'(cnt_reset), 1);
      reset = 1'b1;

      // Count 0..11 and forced wrap
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("run_flag", int'(running), 1);
      chk("cnt_q0", int'(cnt_q), 0);
      for (int i = 1; i <= 11; i++) begin
         step(1);
         chk("cnt_seq", int'(cnt_q), i);
         chk("wrap_seq", int'(wrap), (i == 11) ? 1 : 0);
      end
      step(1);
      chk("cnt_wrapped", int'(cnt_q), 0);
      chk("wrap_after", int'(wrap), 0);

      // Stop at 5: the stop edge still increments, then hold at 6
      step(5);
      chk("cnt_at5", int'(cnt_q), 5);
      stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("hold_q", int'(cnt_q), 6);
         chk("hold_load", int'(cnt_load), 1);
         chk("hold_running", int'(running), 0);
      end
      stop = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("resume_q", int'(cnt_q), 6);
      step(1);
      chk("resume_q7", int'(cnt_q), 7);
      step(1);
      chk("resume_q8", int'(cnt_q), 8);

      // start and stop together: stop wins
      start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      chk("both_running", int'(running), 0);
      chk("both_q", int'(cnt_q), 9);
      step(1);
      chk("both_hold", int'(cnt_q), 9);

      // Hold-mode load from requester 0
      req = 2'b01; req_data = {4'd0, 4'd4};
      push(2'b01, 1'b0);
      step(1);
      req = '0;
      chk("load_pre", int'(cnt_q), 9);
      step(1);
      chk("load_q", int'(cnt_q), 4);
      step(2);
      chk("load_stay", int'(cnt_q), 4);

      // Both requesting: grants alternate 1,0,1,0
      req = 2'b11; req_data = {4'd7, 4'd3};
      push(2'b10, 1'b0); push(2'b01, 1'b0); push(2'b10, 1'b0); push(2'b01, 1'b0);
      begin
         int exp_q[8] = '{4, 7, 7, 3, 3, 7, 7, 3};
         for (int i = 0; i < 8; i++) begin
            step(1);
            chk("rr_q", int'(cnt_q), exp_q[i]);
         end
      end
      req = '0;

      // Out-of-range data: error pulse, no load, pointer moves to 1
      req = 2'b10; req_data = {4'd13, 4'd0};
      push(2'b10, 1'b1);
      step(1);
      req = '0;
      chk("err_q", int'(cnt_q), 3);
      step(1);
      chk("err_q_stay", int'(cnt_q), 3);
      req = 2'b11; req_data = {4'd5, 4'd2};
      push(2'b01, 1'b0);
      step(1);
      req = '0;
      step(1);
      chk("ptr_after_err", int'(cnt_q), 2);

      // Run up to 8, then clear and req together: clear wins
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(6);
      chk("pre_clear", int'(cnt_q), 8);
      clear = 1'b1; req = 2'b01; req_data = {4'd0, 4'd4};
      step(1);
      clear = 1'b0; req = '0;
      chk("clear_gnt", int'(gnt), 0);
      chk("clear_q1", int'(cnt_q), 9);
      step(1);
      chk("clear_q", int'(cnt_q), 0);
      step(1);
      chk("clear_resume", int'(cnt_q), 1);

      // Reset while in LOAD abandons the load
      req = 2'b01; req_data = {4'd0, 4'd6};
      @(posedge clk);
      #1;
      req = '0;
      reset = 1'b0;
      step(2);
      chk("midrst_q", int'(cnt_q), 0);
      chk("midrst_gnt", int'(gnt), 0);
      reset = 1'b1;
      step(3);
      chk("post_rst_q", int'(cnt_q), 0);
      chk("post_rst_running", int'(running), 0);
      chk("post_rst_gnt", int'(gnt), 0);

      // Illegal Q of 12 while running is treated as a wrap
      start = 1'b1;
      step(1);
      start = 1'b0;
      glitch = 1'b1;
      step(1);
      glitch = 1'b0;
      chk("glitch_q", int'(cnt_q), 12);
      chk("glitch_wrap", int'(wrap), 1);
      chk("glitch_load", int'(cnt_load), 1);
      chk("glitch_data", int'(cnt_data), 0);
      step(1);
      chk("glitch_recover", int'(cnt_q), 0);

      stop = 1'b1;
      step(3);
      chk("grants_outstanding", gq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
